// File: rtl/ahb_master.sv
// AHB-Lite initiator: turns single/incrementing-burst commands into pipelined AHB
// transfers and reports per-beat read data and error status on a response pulse.
module ahb_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_pop,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_last,
    output logic [1:0]        htrans,
    output logic [ADDR_W-1:0] haddr,
    output logic              hwrite,
    output logic [DATA_W-1:0] hwdata,
    output logic              hready_in,
    input  logic              hreadyout,
    input  logic [1:0]        hresp,
    input  logic [DATA_W-1:0] hrdata
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAddr = 2'd1;
    localparam logic [1:0] StLast = 2'd2;
    localparam logic [1:0] StErr  = 2'd3;

    localparam logic [1:0] TrIdle   = 2'b00;
    localparam logic [1:0] TrNonseq = 2'b10;
    localparam logic [1:0] TrSeq    = 2'b11;

    logic [1:0]        state_q, state_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [DATA_W-1:0] wbuf_q, wbuf_d;
    logic              wr_pop_q, wr_pop_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_last_q, rsp_last_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              dp_valid_q, dp_valid_d;
    logic              dp_last_q, dp_last_d;
    logic [ADDR_W-1:0] next_addr;
    logic              dp_err;

    assign next_addr = haddr_q + ADDR_W'(4);
    assign dp_err    = dp_valid_q && (hresp != 2'b00);

    always_comb begin
        state_d     = state_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        cmd_ready_d = cmd_ready_q;
        remaining_d = remaining_q;
        dp_valid_d  = dp_valid_q;
        dp_last_d   = dp_last_q;
        wr_pop_d    = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        rsp_last_d  = 1'b0;
        // A popped word may have to wait out a stalled data phase before reaching hwdata.
        wbuf_d      = wr_pop_q ? wr_data : wbuf_q;

        case (state_q)
            StIdle: begin
                if (!cmd_ready_q) begin
                    cmd_ready_d = 1'b1;
                end else if (cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    haddr_d     = cmd_addr;
                    hwrite_d    = cmd_write;
                    remaining_d = cmd_len;
                    htrans_d    = TrNonseq;
                    wr_pop_d    = cmd_write;
                    dp_valid_d  = 1'b0;
                    state_d     = StAddr;
                end
            end
            StAddr, StLast: begin
                if (dp_err && !hreadyout) begin
                    htrans_d = TrIdle;
                    state_d  = StErr;
                end else if (hreadyout) begin
                    if (dp_valid_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = dp_err;
                        rsp_last_d  = dp_last_q | dp_err;
                        rsp_rdata_d = (hwrite_q || dp_err) ? '0 : hrdata;
                    end
                    if (dp_err || state_q == StLast) begin
                        htrans_d   = TrIdle;
                        dp_valid_d = 1'b0;
                        state_d    = StIdle;
                    end else begin
                        dp_valid_d = 1'b1;
                        dp_last_d  = (remaining_q == '0);
                        if (hwrite_q) begin
                            hwdata_d = wr_pop_q ? wr_data : wbuf_q;
                        end
                        if (remaining_q != '0) begin
                            haddr_d     = next_addr;
                            htrans_d    = (next_addr[9:0] == 10'd0) ? TrNonseq : TrSeq;
                            remaining_d = remaining_q - LEN_W'(1);
                            wr_pop_d    = hwrite_q;
                        end else begin
                            htrans_d = TrIdle;
                            state_d  = StLast;
                        end
                    end
                end
            end
            StErr: begin
                if (hreadyout) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_last_d  = 1'b1;
                    dp_valid_d  = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= StIdle;
            htrans_q    <= TrIdle;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            wbuf_q      <= '0;
            wr_pop_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            remaining_q <= '0;
            dp_valid_q  <= 1'b0;
            dp_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            wbuf_q      <= wbuf_d;
            wr_pop_q    <= wr_pop_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
            cmd_ready_q <= cmd_ready_d;
            remaining_q <= remaining_d;
            dp_valid_q  <= dp_valid_d;
            dp_last_q   <= dp_last_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wr_pop    = wr_pop_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_last  = rsp_last_q;
    assign htrans    = htrans_q;
    assign haddr     = haddr_q;
    assign hwrite    = hwrite_q;
    assign hwdata    = hwdata_q;
    assign hready_in = hreadyout;

endmodule

// File: tb/tb_ahb_master.sv
// Bench for ahb_master: table of commands run against a small AHB slave model,
// with a response scoreboard and bus-protocol monitors.
module tb_ahb_master;
    logic        hclk;
    logic        hresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_pop;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_last;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        hready_in;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;

    ahb_master #(.ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
        .hclk(hclk), .hresetn(hresetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wr_data(wr_data),
        .wr_pop(wr_pop), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_last(rsp_last), .htrans(htrans), .haddr(haddr), .hwrite(hwrite),
        .hwdata(hwdata), .hready_in(hready_in), .hreadyout(hreadyout), .hresp(hresp),
        .hrdata(hrdata)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  len;
        int          waits;
        int          err_beat;
        logic [31:0] rd_xor;
        logic [31:0] wd_base;
        int          exp_beats;
        int          exp_pops;
        int          exp_rsp;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        last;
    } rsp_t;

    int n_checks = 0;
    int n_fail   = 0;
    rsp_t        sb[$];
    logic [31:0] addr_log[$];
    logic [1:0]  trans_log[$];
    int n_rsp  = 0;
    int n_pops = 0;

    // slave model configuration and state
    int          cfg_waits    = 0;
    int          cfg_err_beat = -1;
    logic [31:0] rd_xor       = 32'h0;
    logic [31:0] wd_base      = 32'h0;
    int          beat_cnt     = 0;
    int          pop_idx      = 0;
    logic        dp_pend      = 1'b0;
    logic [31:0] dp_addr      = 32'h0;
    logic        dp_write     = 1'b0;
    int          dp_idx       = 0;
    int          wait_left    = 0;
    logic        err_seen     = 1'b0;
    logic [1:0]  s_htrans;
    logic [31:0] s_haddr;
    logic        s_hwrite;
    logic        s_wr_pop;

    assign wr_data = wd_base ^ (32'(pop_idx) * 32'h1111_0000);

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic slave_step();
        if (!hresetn) begin
            dp_pend = 1'b0; pop_idx = 0;
            hreadyout = 1'b1; hresp = 2'b00; hrdata = 32'h0;
            return;
        end
        if (hreadyout) begin
            dp_pend = s_htrans[1];
            if (dp_pend) begin
                dp_addr = s_haddr; dp_write = s_hwrite; dp_idx = beat_cnt;
                beat_cnt++; wait_left = cfg_waits; err_seen = 1'b0;
            end
        end
        if (s_wr_pop) pop_idx++;
        hresp = 2'b00; hrdata = 32'h0; hreadyout = 1'b1;
        if (dp_pend) begin
            if (dp_idx == cfg_err_beat) begin
                hresp = 2'b01; hreadyout = err_seen; err_seen = 1'b1;
            end else if (wait_left > 0) begin
                hreadyout = 1'b0; wait_left--;
            end else if (!dp_write) begin
                hrdata = rd_xor ^ dp_addr;
            end
        end
    endtask

    initial begin
        hreadyout = 1'b1; hresp = 2'b00; hrdata = 32'h0;
        forever begin
            @(negedge hclk);
            s_htrans = htrans; s_haddr = haddr; s_hwrite = hwrite; s_wr_pop = wr_pop;
            @(posedge hclk);
            #1;
            slave_step();
        end
    end

    // Monitor: scoreboard pop, write-data check, stall hold and error cancel rules.
    initial begin
        logic        prev_err1 = 1'b0;
        logic        prev_stall = 1'b0;
        logic [1:0]  prev_htrans = 2'b00;
        logic [31:0] prev_haddr = 32'h0;
        logic        prev_hwrite = 1'b0;
        rsp_t        r;
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                prev_err1 = 1'b0; prev_stall = 1'b0;
            end else begin
                check("hready_in", hready_in, hreadyout);
                if (prev_err1) check("err_cancel_htrans", htrans, 2'b00);
                if (prev_stall) check("stall_hold", {htrans, haddr, hwrite},
                                      {prev_htrans, prev_haddr, prev_hwrite});
                if (rsp_valid) begin
                    n_rsp++;
                    if (sb.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL rsp_unexpected got rdata=%0h err=%0b last=%0b expected none",
                                 rsp_rdata, rsp_err, rsp_last);
                    end else begin
                        r = sb.pop_front();
                        check("rsp", {rsp_rdata, rsp_err, rsp_last}, {r.rdata, r.err, r.last});
                    end
                end
                if (dp_pend && dp_write && hreadyout && hresp == 2'b00)
                    check("hwdata", hwdata, wd_base ^ (32'(dp_idx) * 32'h1111_0000));
                if (wr_pop) n_pops++;
                if (hreadyout && htrans[1]) begin
                    addr_log.push_back(haddr); trans_log.push_back(htrans);
                end
                prev_err1   = (hresp == 2'b01) && !hreadyout;
                prev_stall  = !hreadyout && (hresp == 2'b00) && (htrans != 2'b00);
                prev_htrans = htrans; prev_haddr = haddr; prev_hwrite = hwrite;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_htrans"}, htrans, 2'b00);
        check({tag, "_haddr"}, haddr, 32'h0);
        check({tag, "_hwrite"}, hwrite, 1'b0);
        check({tag, "_hwdata"}, hwdata, 32'h0);
        check({tag, "_wr_pop"}, wr_pop, 1'b0);
        check({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_last, rsp_rdata}, 35'h0);
        check({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    endtask

    task automatic run_cmd(input vec_t v);
        int          nb;
        int          budget;
        logic [31:0] a;
        logic [1:0]  exp_tr;
        rsp_t        r;
        cfg_waits = v.waits; cfg_err_beat = v.err_beat; rd_xor = v.rd_xor; wd_base = v.wd_base;
        beat_cnt = 0; pop_idx = 0; n_pops = 0; n_rsp = 0;
        addr_log.delete(); trans_log.delete();
        nb = int'(v.len) + 1;
        for (int k = 0; k < nb; k++) begin
            a = v.addr + 32'(4 * k);
            if (k == v.err_beat) begin
                r.rdata = 32'h0; r.err = 1'b1; r.last = 1'b1;
                sb.push_back(r);
                break;
            end
            r.rdata = v.wr ? 32'h0 : (v.rd_xor ^ a);
            r.err = 1'b0; r.last = (k == nb - 1);
            sb.push_back(r);
        end
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
        budget = 0;
        while (!cmd_ready && budget < 50) begin tick(); budget++; end
        if (!cmd_ready) begin
            n_checks++; n_fail++;
            $display("FAIL cmd_accept got cmd_ready=0 expected 1 within 50 cycles");
            cmd_valid = 1'b0; sb.delete();
            return;
        end
        tick();
        cmd_valid = 1'b0;
        if (v.len == 4'd0 && v.waits == 0 && v.err_beat < 0) begin
            check("lat_t1_htrans", htrans, 2'b10);
            check("lat_t1_wr_pop", wr_pop, v.wr);
            check("lat_t1_haddr", haddr, v.addr);
            tick();
            if (v.wr) check("lat_t2_hwdata", hwdata, v.wd_base);
            check("lat_t2_rsp_early", rsp_valid, 1'b0);
            tick();
            check("lat_t3_rsp", {rsp_valid, rsp_last, rsp_err}, 3'b110);
        end
        budget = 0;
        while (!cmd_ready && budget < 300) begin tick(); budget++; end
        check("cmd_done", cmd_ready, 1'b1);
        check("sb_empty", sb.size(), 0);
        check("n_rsp", n_rsp, v.exp_rsp);
        check("n_pops", n_pops, v.exp_pops);
        check("n_beats", addr_log.size(), v.exp_beats);
        for (int i = 0; i < addr_log.size() && i < v.exp_beats; i++) begin
            a = v.addr + 32'(4 * i);
            exp_tr = (i == 0 || a[9:0] == 10'h0) ? 2'b10 : 2'b11;
            check("beat_haddr", addr_log[i], a);
            check("beat_htrans", trans_log[i], exp_tr);
        end
        sb.delete();
    endtask

    task automatic reset_mid();
        cfg_waits = 2; cfg_err_beat = -1; wd_base = 32'h5555_0000; beat_cnt = 0; pop_idx = 0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h200; cmd_len = 4'd3;
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        check("mid_busy_htrans", htrans, 2'b11);
        #2 hresetn = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        repeat (2) @(posedge hclk);
        #1 hresetn = 1'b1;
        repeat (3) tick();
        check("post_rst_rsp_valid", rsp_valid, 1'b0);
        check("post_rst_cmd_ready", cmd_ready, 1'b1);
    endtask

    vec_t vecs[8];

    initial begin
        //          wr    addr          len    w  err rd_xor                     wd_base       b  p  r
        vecs[0] = '{1'b1, 32'h0000_0010, 4'd0,  0, -1, 32'h0,                     32'hDEAD_BEEF, 1, 1, 1};
        vecs[1] = '{1'b0, 32'h0000_0020, 4'd0,  2, -1, 32'h1234_5678 ^ 32'h20,     32'h0,         1, 0, 1};
        vecs[2] = '{1'b1, 32'h0000_0100, 4'd3,  0, -1, 32'h0,                     32'hA0A0_0000, 4, 4, 4};
        vecs[3] = '{1'b0, 32'h0000_0100, 4'd3,  0,  1, 32'hCAFE_0000,             32'h0,         2, 0, 2};
        vecs[4] = '{1'b0, 32'h0000_03FC, 4'd1,  0, -1, 32'h0F0F_0000,             32'h0,         2, 0, 2};
        vecs[5] = '{1'b1, 32'h0000_0040, 4'd2,  1, -1, 32'h0,                     32'h1357_0000, 3, 3, 3};
        vecs[6] = '{1'b0, 32'h0000_0080, 4'd15, 0, -1, 32'h7777_0000,             32'h0,        16, 0, 16};
        vecs[7] = '{1'b1, 32'h0000_0030, 4'd0,  0,  0, 32'h0,                     32'h0BAD_F00D, 1, 1, 1};

        hresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_len = 4'd0;
        repeat (2) @(posedge hclk);
        #1;
        check_reset_vals("por");
        hresetn = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 8; i++) run_cmd(vecs[i]);
        reset_mid();
        run_cmd(vecs[1]);
        run_cmd(vecs[2]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
